// File: rtl/spi_register_sequencer_pkg.sv
// Shared constants and state encoding for the SPI-to-register-bus sequencer.
package spi_register_sequencer_pkg;

    localparam int CMD_READ_BIT = 7;
    localparam int DEF_ADDR_W   = 7;
    localparam int DEF_DATA_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises RSPCK/MOSI/SSL into the clk domain and flags RSPCK/SSL edges.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_mosi,
    input  logic i_ssl,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ssl_rise,
    output logic o_ssl_fall
);

    logic [SYNC_STAGES-1:0] r_sck;
    logic [SYNC_STAGES-1:0] r_mosi;
    logic [SYNC_STAGES-1:0] r_ssl;
    logic                   r_sck_d;
    logic                   r_ssl_d;

    // SSL resets deselected so leaving reset never looks like a frame edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck   <= '0;
            r_mosi  <= '0;
            r_ssl   <= '1;
            r_sck_d <= 1'b0;
            r_ssl_d <= 1'b1;
        end else begin
            r_sck   <= {r_sck[SYNC_STAGES-2:0], i_sck};
            r_mosi  <= {r_mosi[SYNC_STAGES-2:0], i_mosi};
            r_ssl   <= {r_ssl[SYNC_STAGES-2:0], i_ssl};
            r_sck_d <= r_sck[SYNC_STAGES-1];
            r_ssl_d <= r_ssl[SYNC_STAGES-1];
        end
    end

    assign o_mosi     = r_mosi[SYNC_STAGES-1];
    assign o_sck_rise =  r_sck[SYNC_STAGES-1] & ~r_sck_d;
    assign o_sck_fall = ~r_sck[SYNC_STAGES-1] &  r_sck_d;
    assign o_ssl_rise =  r_ssl[SYNC_STAGES-1] & ~r_ssl_d;
    assign o_ssl_fall = ~r_ssl[SYNC_STAGES-1] &  r_ssl_d;

endmodule

// File: rtl/spi_register_sequencer.sv
// SPI slave front end that turns command/data bytes into auto-incrementing
// register writes and prefetching register reads.
module spi_register_sequencer
    import spi_register_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RSPCK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              SSL,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_active,
    output logic              frame_error
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic w_mosi, w_sck_rise, w_sck_fall, w_ssl_rise, w_ssl_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (RSPCK),
        .i_mosi     (MOSI),
        .i_ssl      (SSL),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_ssl_rise (w_ssl_rise),
        .o_ssl_fall (w_ssl_fall)
    );

    state_t              r_state, w_next;
    logic [2:0]          r_cnt;
    logic [DATA_W-2:0]   r_rx;
    logic [DATA_W-1:0]   r_tx;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we, r_re, r_re_d, r_err;

    logic                w_active, w_rise, w_fall, w_byte_done;
    logic [DATA_W-1:0]   w_byte;

    // Edges only count inside a frame; state drops to IDLE on the SSL-rise
    // edge, so a byte completing in that same clk still lands.
    assign w_active    = (r_state != ST_IDLE);
    assign w_rise      = w_sck_rise & w_active;
    assign w_fall      = w_sck_fall & w_active;
    assign w_byte_done = w_rise & (r_cnt == 3'd7);
    assign w_byte      = {r_rx, w_mosi};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_ssl_fall) w_next = ST_CMD;
            ST_CMD:  if (w_byte_done) w_next = w_byte[CMD_READ_BIT] ? ST_RDATA : ST_WDATA;
            default: w_next = r_state;
        endcase
        if (w_ssl_rise) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 3'd0;
            r_rx    <= '0;
            r_tx    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_re_d  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_err  <= 1'b0;
            r_re_d <= r_re;

            if (r_we) r_addr <= r_addr + ADDR_ONE;

            if (w_ssl_fall) begin
                r_cnt <= 3'd0;
                r_rx  <= '0;
            end else if (w_ssl_rise) begin
                r_cnt <= 3'd0;
                r_err <= w_active & (r_cnt != 3'd0) & ~w_byte_done;
            end else if (w_rise) begin
                r_cnt <= r_cnt + 3'd1;
                r_rx  <= w_byte[DATA_W-2:0];
            end

            if (w_byte_done) begin
                case (r_state)
                    ST_CMD: begin
                        r_addr <= w_byte[ADDR_W-1:0];
                        r_re   <= w_byte[CMD_READ_BIT];
                    end
                    ST_WDATA: begin
                        r_wdata <= w_byte;
                        r_we    <= 1'b1;
                    end
                    ST_RDATA: begin
                        r_addr <= r_addr + ADDR_ONE;
                        r_re   <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // The fall right after a byte boundary keeps the freshly loaded
            // MSB on the pin; the other seven falls advance it.
            if (w_ssl_fall)
                r_tx <= '0;
            else if (r_re_d)
                r_tx <= reg_rdata;
            else if (w_fall && r_cnt != 3'd0)
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
        end
    end

    assign MISO         = w_active & r_tx[DATA_W-1];
    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign reg_we       = r_we;
    assign reg_re       = r_re;
    assign frame_active = w_active;
    assign frame_error  = r_err;

endmodule

// File: tb/tb_spi_register_sequencer.sv
// Directed bench: drives SPI frames from the host side and checks bus strobes,
// MISO bytes and frame status against hand-computed values.
module tb_spi_register_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RSPCK = 1'b0;
    logic       MOSI = 1'b0;
    logic       SSL = 1'b1;
    logic       MISO;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_active, frame_error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [128];
    logic [15:0] we_q[$];
    logic [6:0]  re_q[$];
    int          err_n  = 0;
    int          both_n = 0;

    spi_register_sequencer #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .RSPCK        (RSPCK),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .SSL          (SSL),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .frame_active (frame_active),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    // Register file read model: data valid the clk after reg_re
    always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({1'b0, reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if (frame_error) err_n++;
        if (reg_we && reg_re) both_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RSPCK half period of 8 clks; MISO sampled just before each rise
    task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = d[i];
            repeat (8) @(negedge clk);
            rx[i] = MISO;
            RSPCK = 1'b1;
            repeat (8) @(negedge clk);
            RSPCK = 1'b0;
        end
    endtask

    task automatic frame_start();
        SSL = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (8) @(negedge clk);
        SSL = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx0, rx1, rx2;
        logic       seen;
        int         e0;

        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h10] = 8'h3C;
        mem[7'h11] = 8'hC3;

        // Reset state
        #1;
        chk("rst_bus", {25'd0, reg_addr}, 32'h0);
        chk("rst_wdata", {24'd0, reg_wdata}, 32'h0);
        chk("rst_flags", {27'd0, MISO, reg_we, reg_re, frame_active, frame_error}, 32'h0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: write burst
        frame_start();
        chk("t1_active", {31'd0, frame_active}, 32'h1);
        spi_bits(8'h05, 8, rx0);
        spi_bits(8'hAA, 8, rx1);
        spi_bits(8'h55, 8, rx2);
        frame_end();
        chk("t1_we_count", we_q.size(), 32'd2);
        chk("t1_we0", {16'd0, we_q[0]}, 32'h05AA);
        chk("t1_we1", {16'd0, we_q[1]}, 32'h0655);
        chk("t1_err", err_n, 32'd0);
        chk("t1_active_end", {31'd0, frame_active}, 32'h0);
        we_q.delete();

        // 2: read burst with prefetch
        frame_start();
        spi_bits(8'h90, 8, rx0);
        spi_bits(8'h00, 8, rx1);
        spi_bits(8'h00, 8, rx2);
        frame_end();
        chk("t2_miso0", {24'd0, rx0}, 32'h00);
        chk("t2_miso1", {24'd0, rx1}, 32'h3C);
        chk("t2_miso2", {24'd0, rx2}, 32'hC3);
        chk("t2_re_count", re_q.size(), 32'd3);
        chk("t2_re0", {25'd0, re_q[0]}, 32'h10);
        chk("t2_re1", {25'd0, re_q[1]}, 32'h11);
        chk("t2_re2", {25'd0, re_q[2]}, 32'h12);
        chk("t2_no_we", we_q.size(), 32'd0);
        re_q.delete();

        // 3: address wrap
        frame_start();
        spi_bits(8'h7F, 8, rx0);
        spi_bits(8'h11, 8, rx1);
        spi_bits(8'h22, 8, rx2);
        frame_end();
        chk("t3_we_count", we_q.size(), 32'd2);
        chk("t3_we0", {16'd0, we_q[0]}, 32'h7F11);
        chk("t3_we1", {16'd0, we_q[1]}, 32'h0022);
        we_q.delete();

        // 4: abort mid-byte, then a clean frame
        e0 = err_n;
        frame_start();
        spi_bits(8'h20, 8, rx0);
        spi_bits(8'h99, 8, rx1);
        spi_bits(8'hF0, 4, rx2);
        frame_end();
        chk("t4_err_pulse", err_n - e0, 32'd1);
        chk("t4_we_count", we_q.size(), 32'd1);
        chk("t4_we0", {16'd0, we_q[0]}, 32'h2099);
        we_q.delete();
        e0 = err_n;
        frame_start();
        spi_bits(8'h30, 8, rx0);
        spi_bits(8'h77, 8, rx1);
        frame_end();
        chk("t4_next_we", {16'd0, we_q[0]}, 32'h3077);
        chk("t4_next_err", err_n - e0, 32'd0);
        we_q.delete();

        // 5: async reset mid-frame
        frame_start();
        spi_bits(8'h40, 8, rx0);
        spi_bits(8'h01, 8, rx1);
        spi_bits(8'h02, 8, rx2);
        repeat (4) @(negedge clk);
        chk("t5_pre_addr", {25'd0, reg_addr}, 32'h42);
        rst = 1'b1;
        #1;
        chk("t5_rst_addr", {25'd0, reg_addr}, 32'h0);
        chk("t5_rst_wdata", {24'd0, reg_wdata}, 32'h0);
        chk("t5_rst_flags", {27'd0, MISO, reg_we, reg_re, frame_active, frame_error}, 32'h0);
        SSL = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        we_q.delete();
        frame_start();
        spi_bits(8'h50, 8, rx0);
        spi_bits(8'h66, 8, rx1);
        frame_end();
        chk("t5_we_count", we_q.size(), 32'd1);
        chk("t5_we0", {16'd0, we_q[0]}, 32'h5066);
        we_q.delete();
        re_q.delete();

        // 6: RSPCK toggling with SSL high
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            MOSI = i[0];
            RSPCK = ~RSPCK;
            repeat (4) @(negedge clk);
            seen = seen | MISO | frame_active;
        end
        RSPCK = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_strobes", we_q.size() + re_q.size(), 32'd0);
        chk("t6_miso_active", {31'd0, seen}, 32'h0);
        chk("both_strobes", both_n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
